// File: rtl/tap_tms_sequencer.sv
// Command-level TMS sequencer for an IEEE 1149.1 TAP. Walks the TAP through RESET/IDLE/SHIFT
// paths one TMS per clock, keeps a shadow TAP state and flags disagreement with state_obs.
module tap_tms_sequencer #(
  parameter int LEN_W   = 8,
  parameter int OBS_LAT = 1
) (
  input  logic             GCLK_Pad,
  input  logic             TRST_Pad,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [3:0]       state_obs,
  output logic             TMS_Pad,
  output logic [3:0]       tap_state,
  output logic             shift_en,
  output logic             done,
  output logic             mismatch
);

  localparam logic [3:0] ST_TLR = 4'hF, ST_RTI = 4'hC, ST_SELDR = 4'h7, ST_CAPDR = 4'h6;
  localparam logic [3:0] ST_SHDR = 4'h2, ST_EX1DR = 4'h1, ST_PAUDR = 4'h3, ST_EX2DR = 4'h0;
  localparam logic [3:0] ST_UPDDR = 4'h5, ST_SELIR = 4'h4, ST_CAPIR = 4'hE, ST_SHIR = 4'hA;
  localparam logic [3:0] ST_EX1IR = 4'h9, ST_PAUIR = 4'hB, ST_EX2IR = 4'h8, ST_UPDIR = 4'hD;
  localparam int HD = (OBS_LAT > 0) ? OBS_LAT : 1;

  typedef enum logic [2:0] {S_INIT, S_READY, S_PRE, S_SHIFT, S_POST, S_RSTSEQ} fsm_t;

  fsm_t                   r_fsm, w_fsm_nxt;
  logic [2:0]             r_step, w_step_nxt;
  logic [LEN_W-1:0]       r_cnt, w_cnt_nxt, w_len_m1;
  logic                   r_tms, r_shift_en, r_done, r_mm;
  logic [3:0]             r_tap, w_tap_dly;
  logic [HD-1:0][3:0]     r_hist;
  logic [2:0]             r_warm;
  logic                   w_tms, w_shift, w_done, w_ready, w_accept, w_chk_en;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    case (s)
      ST_TLR:   tap_next = tms ? ST_TLR   : ST_RTI;
      ST_RTI:   tap_next = tms ? ST_SELDR : ST_RTI;
      ST_SELDR: tap_next = tms ? ST_SELIR : ST_CAPDR;
      ST_CAPDR: tap_next = tms ? ST_EX1DR : ST_SHDR;
      ST_SHDR:  tap_next = tms ? ST_EX1DR : ST_SHDR;
      ST_EX1DR: tap_next = tms ? ST_UPDDR : ST_PAUDR;
      ST_PAUDR: tap_next = tms ? ST_EX2DR : ST_PAUDR;
      ST_EX2DR: tap_next = tms ? ST_UPDDR : ST_SHDR;
      ST_UPDDR: tap_next = tms ? ST_SELDR : ST_RTI;
      ST_SELIR: tap_next = tms ? ST_TLR   : ST_CAPIR;
      ST_CAPIR: tap_next = tms ? ST_EX1IR : ST_SHIR;
      ST_SHIR:  tap_next = tms ? ST_EX1IR : ST_SHIR;
      ST_EX1IR: tap_next = tms ? ST_UPDIR : ST_PAUIR;
      ST_PAUIR: tap_next = tms ? ST_EX2IR : ST_PAUIR;
      ST_EX2IR: tap_next = tms ? ST_UPDIR : ST_SHIR;
      ST_UPDIR: tap_next = tms ? ST_SELDR : ST_RTI;
      default:  tap_next = ST_TLR;
    endcase
  endfunction

  // done is still high in the first READY cycle, so hold off the next accept by one cycle
  assign w_ready  = (r_fsm == S_READY) && !r_done;
  assign w_accept = cmd_valid && w_ready;
  assign w_len_m1 = (cmd_len == '0) ? '0 : cmd_len - LEN_W'(1);
  assign w_chk_en = (r_warm == 3'(OBS_LAT + 1));

  generate
    if (OBS_LAT == 0) begin : g_nodly
      assign w_tap_dly = r_tap;
    end else begin : g_dly
      assign w_tap_dly = r_hist[HD-1];
    end
  endgenerate

  always_ff @(posedge GCLK_Pad) begin
    if (TRST_Pad) begin
      r_fsm      <= S_INIT;
      r_step     <= '0;
      r_cnt      <= '0;
      r_tms      <= 1'b0;
      r_tap      <= ST_TLR;
      r_shift_en <= 1'b0;
      r_done     <= 1'b0;
      r_mm       <= 1'b0;
      r_hist     <= {HD{ST_TLR}};
      r_warm     <= '0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_step     <= w_step_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tms      <= w_tms;
      r_tap      <= tap_next(r_tap, w_tms);
      r_shift_en <= w_shift;
      r_done     <= w_done;
      r_hist[0]  <= r_tap;
      for (int i = 1; i < HD; i++) r_hist[i] <= r_hist[i-1];
      if (!w_chk_en) r_warm <= r_warm + 3'd1;
      if (w_chk_en && (w_tap_dly != state_obs)) r_mm <= 1'b1;
    end
  end

  // PRE steps 0..3 emit 1,1,0,0; DR enters at step 1 to get 1,0,0. IDLE reuses the last RSTSEQ step.
  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_step_nxt = r_step;
    w_cnt_nxt  = r_cnt;
    case (r_fsm)
      S_INIT: w_fsm_nxt = S_READY;
      S_READY: begin
        if (w_accept) begin
          case (cmd_op)
            2'b00: begin w_fsm_nxt = S_RSTSEQ; w_step_nxt = 3'd0; end
            2'b01: begin w_fsm_nxt = S_RSTSEQ; w_step_nxt = 3'd5; end
            2'b10: begin w_fsm_nxt = S_PRE; w_step_nxt = 3'd0; w_cnt_nxt = w_len_m1; end
            default: begin w_fsm_nxt = S_PRE; w_step_nxt = 3'd1; w_cnt_nxt = w_len_m1; end
          endcase
        end
      end
      S_PRE: begin
        if (r_step == 3'd3) w_fsm_nxt = S_SHIFT;
        else                w_step_nxt = r_step + 3'd1;
      end
      S_SHIFT: begin
        if (r_cnt == '0) begin
          w_fsm_nxt  = S_POST;
          w_step_nxt = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt - LEN_W'(1);
        end
      end
      S_POST: begin
        if (r_step == 3'd1) w_fsm_nxt = S_READY;
        else                w_step_nxt = r_step + 3'd1;
      end
      S_RSTSEQ: begin
        if (r_step == 3'd5) w_fsm_nxt = S_READY;
        else                w_step_nxt = r_step + 3'd1;
      end
      default: w_fsm_nxt = S_INIT;
    endcase
  end

  always_comb begin
    w_tms   = 1'b0;
    w_shift = 1'b0;
    w_done  = 1'b0;
    case (r_fsm)
      S_PRE:    w_tms = (r_step < 3'd2);
      S_SHIFT:  begin w_tms = (r_cnt == '0); w_shift = 1'b1; end
      S_POST:   begin w_tms = (r_step == 3'd0); w_done = (r_step != 3'd0); end
      S_RSTSEQ: begin w_tms = (r_step != 3'd5); w_done = (r_step == 3'd5); end
      default:  w_tms = 1'b0;
    endcase
  end

  assign cmd_ready = w_ready;
  assign TMS_Pad   = r_tms;
  assign tap_state = r_tap;
  assign shift_en  = r_shift_en;
  assign done      = r_done;
  assign mismatch  = r_mm;

endmodule

// File: tb/tb_tap_tms_sequencer.sv
// Directed bench for tap_tms_sequencer: per-cycle expectations queued at command issue and
// popped each cycle; state_obs comes from an independent TAP model driven by TMS_Pad.
module tb_tap_tms_sequencer;
  localparam int LEN_W   = 8;
  localparam int OBS_LAT = 1;

  logic             GCLK_Pad = 1'b0;
  logic             TRST_Pad = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [3:0]       state_obs;
  logic             TMS_Pad;
  logic [3:0]       tap_state;
  logic             shift_en, done, mismatch;

  logic [3:0] tb_tap;
  logic       force_obs = 1'b0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       tms;
    logic [3:0] st;
    logic       sh;
    logic       dn;
    logic       rdy;
  } exp_t;
  exp_t sb[$];

  localparam logic       T2  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [3:0] S2  [8] = '{4'h7, 4'h6, 4'h2, 4'h2, 4'h2, 4'h1, 4'h5, 4'hC};
  localparam logic       SH2 [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic       T3  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [3:0] S3  [7] = '{4'h7, 4'h4, 4'hE, 4'hA, 4'h9, 4'hD, 4'hC};
  localparam logic       SH3 [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  tap_tms_sequencer #(.LEN_W(LEN_W), .OBS_LAT(OBS_LAT)) dut (
    .GCLK_Pad (GCLK_Pad),
    .TRST_Pad (TRST_Pad),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_len  (cmd_len),
    .state_obs(state_obs),
    .TMS_Pad  (TMS_Pad),
    .tap_state(tap_state),
    .shift_en (shift_en),
    .done     (done),
    .mismatch (mismatch)
  );

  always #5 GCLK_Pad = ~GCLK_Pad;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic t);
    case (s)
      4'hF: tap_next = t ? 4'hF : 4'hC;
      4'hC: tap_next = t ? 4'h7 : 4'hC;
      4'h7: tap_next = t ? 4'h4 : 4'h6;
      4'h6: tap_next = t ? 4'h1 : 4'h2;
      4'h2: tap_next = t ? 4'h1 : 4'h2;
      4'h1: tap_next = t ? 4'h5 : 4'h3;
      4'h3: tap_next = t ? 4'h0 : 4'h3;
      4'h0: tap_next = t ? 4'h5 : 4'h2;
      4'h5: tap_next = t ? 4'h7 : 4'hC;
      4'h4: tap_next = t ? 4'hF : 4'hE;
      4'hE: tap_next = t ? 4'h9 : 4'hA;
      4'hA: tap_next = t ? 4'h9 : 4'hA;
      4'h9: tap_next = t ? 4'hD : 4'hB;
      4'hB: tap_next = t ? 4'h8 : 4'hB;
      4'h8: tap_next = t ? 4'hD : 4'hA;
      4'hD: tap_next = t ? 4'h7 : 4'hC;
      default: tap_next = 4'hF;
    endcase
  endfunction

  // Device-side TAP: moves on the TMS it actually sees
  always @(posedge GCLK_Pad) tb_tap <= TRST_Pad ? 4'hF : tap_next(tb_tap, TMS_Pad);
  assign state_obs = force_obs ? 4'h0 : tb_tap;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic push_cmd(input logic [1:0] op, input int len);
    logic tl[$];
    logic [3:0] s, p;
    int n;
    n = (len == 0) ? 1 : len;
    tl = {};
    if (op == 2'b00) begin
      repeat (5) tl.push_back(1'b1);
      tl.push_back(1'b0);
    end else if (op == 2'b01) begin
      tl.push_back(1'b0);
    end else begin
      tl.push_back(1'b1);
      if (op == 2'b10) tl.push_back(1'b1);
      tl.push_back(1'b0); tl.push_back(1'b0);
      for (int i = 0; i < n - 1; i++) tl.push_back(1'b0);
      tl.push_back(1'b1); tl.push_back(1'b1); tl.push_back(1'b0);
    end
    s = 4'hC;
    for (int i = 0; i < tl.size(); i++) begin
      p = s;
      s = tap_next(s, tl[i]);
      sb.push_back('{tl[i], s, (p == 4'h2) || (p == 4'hA), (i == tl.size() - 1), 1'b0});
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [LEN_W-1:0] len, input bit hold);
    int n;
    n = 0;
    cmd_op = op; cmd_len = len; cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      @(posedge GCLK_Pad); #1; n++;
    end
    chk("ready_before_accept", cmd_ready, 1);
    @(posedge GCLK_Pad); #1;
    if (!hold) cmd_valid = 1'b0;
    chk("ready_after_accept", cmd_ready, 0);
  endtask

  task automatic drain(input int n);
    exp_t e;
    for (int i = 0; i < n && sb.size() > 0; i++) begin
      @(posedge GCLK_Pad); #1;
      e = sb.pop_front();
      chk($sformatf("tms[%0d]", i), TMS_Pad, e.tms);
      chk($sformatf("tap_state[%0d]", i), tap_state, e.st);
      chk($sformatf("shift_en[%0d]", i), shift_en, e.sh);
      chk($sformatf("done[%0d]", i), done, e.dn);
      chk($sformatf("cmd_ready[%0d]", i), cmd_ready, e.rdy);
    end
  endtask

  initial begin
    // Reset and INIT
    TRST_Pad = 1'b1;
    repeat (2) @(posedge GCLK_Pad);
    #1;
    chk("rst_tms", TMS_Pad, 0);
    chk("rst_tap", tap_state, 4'hF);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_shift", shift_en, 0);
    chk("rst_done", done, 0);
    chk("rst_mismatch", mismatch, 0);
    TRST_Pad = 1'b0;
    @(posedge GCLK_Pad); #1;
    chk("init_tms", TMS_Pad, 0);
    chk("init_tap", tap_state, 4'hC);
    chk("init_ready", cmd_ready, 1);

    // SHIFT_DR len=3 against literal expectations
    issue(2'b11, 8'd3, 1'b0);
    for (int i = 0; i < 8; i++) sb.push_back('{T2[i], S2[i], SH2[i], (i == 7), 1'b0});
    drain(8);
    @(posedge GCLK_Pad); #1;
    chk("dr3_ready_after_done", cmd_ready, 1);

    // SHIFT_IR len=1, then len=0 behaves as len=1
    issue(2'b10, 8'd1, 1'b0);
    for (int i = 0; i < 7; i++) sb.push_back('{T3[i], S3[i], SH3[i], (i == 6), 1'b0});
    drain(7);
    issue(2'b10, 8'd0, 1'b0);
    for (int i = 0; i < 7; i++) sb.push_back('{T3[i], S3[i], SH3[i], (i == 6), 1'b0});
    drain(7);

    // IDLE and the longest shift
    issue(2'b01, 8'd0, 1'b0);
    push_cmd(2'b01, 0);
    drain(1);
    issue(2'b11, 8'd255, 1'b0);
    push_cmd(2'b11, 255);
    drain(260);

    // RESET then SHIFT_DR len=2 with valid held; op change while busy must not matter
    issue(2'b00, 8'd0, 1'b1);
    cmd_op = 2'b11; cmd_len = 8'd2;
    push_cmd(2'b00, 0);
    sb.push_back('{1'b0, 4'hC, 1'b0, 1'b0, 1'b1});
    sb.push_back('{1'b0, 4'hC, 1'b0, 1'b0, 1'b0});
    push_cmd(2'b11, 2);
    drain(8);
    cmd_valid = 1'b0;
    drain(7);
    chk("b2b_mismatch", mismatch, 0);

    // Reset in the middle of Shift-DR
    issue(2'b11, 8'd10, 1'b0);
    push_cmd(2'b11, 10);
    drain(5);
    chk("mid_in_shdr", tap_state, 4'h2);
    TRST_Pad = 1'b1;
    @(posedge GCLK_Pad); #1;
    TRST_Pad = 1'b0;
    sb.delete();
    chk("abort_tap", tap_state, 4'hF);
    chk("abort_done", done, 0);
    chk("abort_ready", cmd_ready, 0);
    chk("abort_tms", TMS_Pad, 0);
    chk("abort_shift", shift_en, 0);
    @(posedge GCLK_Pad); #1;
    chk("abort_init_tap", tap_state, 4'hC);
    chk("abort_init_ready", cmd_ready, 1);
    chk("abort_init_done", done, 0);

    // Glitch on state_obs during SHIFT_IR
    chk("pre_glitch_mismatch", mismatch, 0);
    issue(2'b10, 8'd4, 1'b0);
    push_cmd(2'b10, 4);
    drain(4);
    force_obs = 1'b1;
    drain(1);
    force_obs = 1'b0;
    chk("glitch_mismatch", mismatch, 1);
    drain(5);
    repeat (3) @(posedge GCLK_Pad);
    #1;
    chk("mismatch_sticky", mismatch, 1);
    TRST_Pad = 1'b1;
    @(posedge GCLK_Pad); #1;
    TRST_Pad = 1'b0;
    chk("mismatch_cleared", mismatch, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
